wbutxarbiter: RTL and testbench
===============================

Name: wbutxarbiter

Overview:
Shares the single 8-bit serial TX byte channel between the debug-bus response stream (wbuoutput characters) and a 7-bit console stream.
- Debug bytes go out with bit 7 set; console bytes go out with bit 7 clear.
- Console bytes are buffered in a small FIFO.
- A burst limit stops a long debug-bus readout from starving the console.
- Sits between wbuoutput/console sources and the UART transmitter.

Parameters:
LGCONSOLE_FIFO, 4, log2 depth of console FIFO (depth 16); legal range 1..8.
MAXBURST, 8, max consecutive debug bytes sent while console data is waiting; 0 disables the starvation guard (strict debug priority).

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_cmd_port_active  input  1  1 = debug stream may transmit; 0 = debug bytes accepted and discarded
i_dbg_stb  input  1  debug byte valid
i_dbg_data  input  7  debug byte payload
o_dbg_busy  output  1  debug byte not accepted this cycle (combinational)
i_console_stb  input  1  console byte valid
i_console_data  input  7  console byte payload
o_console_busy  output  1  console FIFO full (registered)
o_console_fill  output  LGCONSOLE_FIFO+1  console FIFO occupancy
o_tx_stb  output  1  TX byte valid
o_tx_data  output  8  TX byte
i_tx_busy  input  1  transmitter cannot take byte

Behaviour:
Reset (async assert, sync-safe release) clears all of:
- o_tx_stb=0, o_tx_data=0
- FIFO empty: o_console_fill=0, o_console_busy=0
- burst counter = 0

Asserting reset mid-operation discards the held TX byte and all FIFO contents.

Console FIFO:
- Write when i_console_stb && !o_console_busy.
- o_console_busy = (fill == 2^LGCONSOLE_FIFO), registered.
- A write while full is a source protocol violation and is ignored.
- A read and a write in the same cycle leave fill unchanged.
- Read/write pointers are LGCONSOLE_FIFO bits wide and wrap modulo depth.
- Data reaches the FIFO head one cycle after the write.

Output holding register:
- load_ok = !o_tx_stb || !i_tx_busy.
- Sustains one byte per clock when the transmitter is never busy.
- When o_tx_stb && !i_tx_busy and nothing is granted, o_tx_stb <= 0.
- o_tx_data holds its value while o_tx_stb && i_tx_busy.

Arbitration (evaluated each cycle when load_ok):
- dreq = i_dbg_stb && i_cmd_port_active; creq = fill != 0.
- Force console when dreq && creq && MAXBURST!=0 && burst==MAXBURST.
  - Load {1'b0, fifo head}, pop FIFO, burst<=0.
  - Debug byte stalls: o_dbg_busy=1.
- Else if dreq:
  - Load {1'b1, i_dbg_data}.
  - burst <= creq ? min(burst+1, MAXBURST) : 0.
- Else if creq: load {1'b0, head}, pop, burst<=0.
- Else: no load, burst<=0.

o_dbg_busy:
- When !i_cmd_port_active: o_dbg_busy=0; debug bytes are swallowed; burst unaffected.
- Otherwise: o_dbg_busy = !(load_ok && debug granted).
- Debug handshake: byte transferred when i_dbg_stb && !o_dbg_busy.

Burst counter:
- Width clog2(MAXBURST+1), minimum 1 bit.
- Never exceeds MAXBURST.

Ordering and latency:
- Console bytes leave in FIFO order, bit 7 always 0.
- A console byte written into an empty FIFO with no debug traffic appears on o_tx_stb 2 cycles after the write cycle (1 cycle to FIFO head, 1 to the output register).
- A granted debug byte appears on o_tx_stb 1 cycle after acceptance.

Test Plan:
- Reset/idle: pulse i_reset_n low mid-transfer with o_tx_stb=1 and fill=3 -> o_tx_stb=0, o_tx_data=0, fill=0 immediately; no output after release.
- Console-only path: write 0x41,0x42,0x43 back-to-back, i_tx_busy=0 -> o_tx_data 0x41,0x42,0x43 on consecutive cycles, first 2 cycles after the 0x41 write; fill returns to 0.
- Starvation guard: MAXBURST=8, i_dbg_stb held with 0x55, console holds 0x30, cmd active -> 8×0xD5, one 0x30, then 0xD5 resumes; o_dbg_busy high exactly on the console-grant cycle.
- FIFO full/backpressure: i_tx_busy=1, dbg idle, write 17 console bytes -> o_console_busy=1 after fill=16, 17th ignored; release i_tx_busy -> 16 bytes out in order, pointer wrap verified.
- Port inactive: i_cmd_port_active=0, 5 debug bytes plus console 0x7E -> o_dbg_busy=0 throughout, only 0x7E transmitted.
- TX stall hold: o_tx_stb=1, o_tx_data=0xC1, i_tx_busy=1 for 10 cycles with new requests pending -> o_tx_data stays 0xC1, no debug accept until i_tx_busy=0.

Source files
------------

// File: rtl/wbutxarbiter_if.sv
// rtl/wbutxarbiter_if.sv - debug/console/TX handshake bundle for the TX byte arbiter
interface wbutxarbiter_if #(
  parameter int LGCONSOLE_FIFO = 4
);
  logic                      i_cmd_port_active;
  logic                      i_dbg_stb;
  logic [6:0]                i_dbg_data;
  logic                      o_dbg_busy;
  logic                      i_console_stb;
  logic [6:0]                i_console_data;
  logic                      o_console_busy;
  logic [LGCONSOLE_FIFO:0]   o_console_fill;
  logic                      o_tx_stb;
  logic [7:0]                o_tx_data;
  logic                      i_tx_busy;

  // Arbiter side
  modport slave (
    input  i_cmd_port_active, i_dbg_stb, i_dbg_data,
    input  i_console_stb, i_console_data, i_tx_busy,
    output o_dbg_busy, o_console_busy, o_console_fill,
    output o_tx_stb, o_tx_data
  );

  // Source / transmitter side
  modport master (
    output i_cmd_port_active, i_dbg_stb, i_dbg_data,
    output i_console_stb, i_console_data, i_tx_busy,
    input  o_dbg_busy, o_console_busy, o_console_fill,
    input  o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/wbutxarbiter.sv
// rtl/wbutxarbiter.sv - shares the serial TX byte channel between debug and console streams
module wbutxarbiter #(
  parameter int LGCONSOLE_FIFO = 4,
  parameter int MAXBURST       = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  wbutxarbiter_if.slave bus
);
  localparam int DEPTH = 1 << LGCONSOLE_FIFO;
  localparam int BW    = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;
  localparam logic [BW-1:0]             BURST_MAX = BW'(MAXBURST);
  localparam logic [BW-1:0]             BURST_ONE = BW'(1);
  localparam logic [LGCONSOLE_FIFO:0]   FILL_FULL = (LGCONSOLE_FIFO + 1)'(DEPTH);
  localparam logic [LGCONSOLE_FIFO:0]   FILL_ONE  = (LGCONSOLE_FIFO + 1)'(1);
  localparam logic [LGCONSOLE_FIFO-1:0] PTR_ONE   = LGCONSOLE_FIFO'(1);

  logic [6:0]                mem [DEPTH];
  logic [LGCONSOLE_FIFO-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LGCONSOLE_FIFO:0]   fill_q, fill_d;
  logic                      full_q, full_d;
  logic                      tx_stb_q, tx_stb_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic [BW-1:0]             burst_q, burst_d;

  logic push, pop, load_ok, dreq, creq, force_con, grant_dbg;
  logic [6:0] head;

  assign head    = mem[rd_ptr_q];
  assign push    = bus.i_console_stb && !full_q;
  assign load_ok = !tx_stb_q || !bus.i_tx_busy;
  assign dreq    = bus.i_dbg_stb && bus.i_cmd_port_active;
  assign creq    = (fill_q != '0);
  assign force_con = dreq && creq && (MAXBURST != 0) && (burst_q == BURST_MAX);

  // Arbitration: choose what the holding register loads and track the debug burst length
  always_comb begin
    tx_stb_d  = tx_stb_q;
    tx_data_d = tx_data_q;
    burst_d   = burst_q;
    pop       = 1'b0;
    grant_dbg = 1'b0;
    if (load_ok) begin
      if (force_con) begin
        tx_stb_d  = 1'b1;
        tx_data_d = {1'b0, head};
        pop       = 1'b1;
        burst_d   = '0;
      end else if (dreq) begin
        tx_stb_d  = 1'b1;
        tx_data_d = {1'b1, bus.i_dbg_data};
        grant_dbg = 1'b1;
        if (!creq)
          burst_d = '0;
        else if (burst_q != BURST_MAX)
          burst_d = burst_q + BURST_ONE;
      end else if (creq) begin
        tx_stb_d  = 1'b1;
        tx_data_d = {1'b0, head};
        pop       = 1'b1;
        burst_d   = '0;
      end else begin
        tx_stb_d  = 1'b0;
        burst_d   = '0;
      end
    end
  end

  // Console FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)
      fill_d = fill_q + FILL_ONE;
    else if (!push && pop)
      fill_d = fill_q - FILL_ONE;
    full_d = (fill_d == FILL_FULL);
  end

  // Console FIFO storage; contents need no reset since fill gates every read
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= bus.i_console_data;
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
      burst_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
      burst_q   <= burst_d;
    end
  end

  // A swallowed debug byte (port inactive) is never reported busy
  assign bus.o_dbg_busy     = bus.i_cmd_port_active && !grant_dbg;
  assign bus.o_console_busy = full_q;
  assign bus.o_console_fill = fill_q;
  assign bus.o_tx_stb       = tx_stb_q;
  assign bus.o_tx_data      = tx_data_q;
endmodule

// File: tb/tb_wbutxarbiter.sv
// tb/tb_wbutxarbiter.sv - directed self-checking bench for wbutxarbiter
module tb_wbutxarbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wbutxarbiter_if #(.LGCONSOLE_FIFO(4)) bus ();

  wbutxarbiter #(.LGCONSOLE_FIFO(4), .MAXBURST(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.o_tx_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %0h expected 0", bus.o_tx_stb); end
    n_cmp++; if (bus.o_tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", bus.o_tx_data); end
    n_cmp++; if (bus.o_console_fill !== 5'd0) begin n_bad++; $display("FAIL reset_fill: got %0d expected 0", bus.o_console_fill); end
    n_cmp++; if (bus.o_console_busy !== 1'b0) begin n_bad++; $display("FAIL reset_cbusy: got %0h expected 0", bus.o_console_busy); end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.o_tx_stb !== 1'b0) begin n_bad++; $display("FAIL idle_stb: got %0h expected 0", bus.o_tx_stb); end
    // Build up a held byte plus three queued console bytes, then reset mid-transfer
    bus.i_tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_console_stb  = 1'b1;
      bus.i_console_data = 7'(32'h10 + i);
      tick();
    end
    bus.i_console_stb = 1'b0;
    n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== 8'h10) begin n_bad++; $display("FAIL pre_reset_tx: got stb=%0h data=%0h expected stb=1 data=10", bus.o_tx_stb, bus.o_tx_data); end
    n_cmp++; if (bus.o_console_fill !== 5'd3) begin n_bad++; $display("FAIL pre_reset_fill: got %0d expected 3", bus.o_console_fill); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_tx_stb !== 1'b0 || bus.o_tx_data !== 8'h00) begin n_bad++; $display("FAIL async_reset_tx: got stb=%0h data=%0h expected 0/0", bus.o_tx_stb, bus.o_tx_data); end
    n_cmp++; if (bus.o_console_fill !== 5'd0) begin n_bad++; $display("FAIL async_reset_fill: got %0d expected 0", bus.o_console_fill); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.o_tx_stb !== 1'b0) begin n_bad++; $display("FAIL post_reset_stb[%0d]: got %0h expected 0", i, bus.o_tx_stb); end
    end
  endtask

  task automatic test_console_only;
    logic       exp_stb;
    logic [7:0] exp_data;
    for (int c = 0; c < 5; c++) begin
      bus.i_console_stb  = (c < 3);
      bus.i_console_data = 7'(32'h41 + c);
      tick();
      exp_stb  = (c >= 1 && c <= 3);
      exp_data = 8'(32'h40 + c);
      n_cmp++; if (bus.o_tx_stb !== exp_stb) begin n_bad++; $display("FAIL console_stb[%0d]: got %0h expected %0h", c, bus.o_tx_stb, exp_stb); end
      if (exp_stb) begin
        n_cmp++; if (bus.o_tx_data !== exp_data) begin n_bad++; $display("FAIL console_data[%0d]: got %0h expected %0h", c, bus.o_tx_data, exp_data); end
      end
    end
    bus.i_console_stb = 1'b0;
    n_cmp++; if (bus.o_console_fill !== 5'd0) begin n_bad++; $display("FAIL console_fill_end: got %0d expected 0", bus.o_console_fill); end
  endtask

  task automatic test_fifo_full;
    // Occupy the holding register with a debug byte so every console byte stays queued
    bus.i_tx_busy  = 1'b1;
    bus.i_dbg_stb  = 1'b1;
    bus.i_dbg_data = 7'h11;
    tick();
    bus.i_dbg_stb = 1'b0;
    n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== 8'h91) begin n_bad++; $display("FAIL full_hold: got stb=%0h data=%0h expected 1/91", bus.o_tx_stb, bus.o_tx_data); end
    for (int i = 0; i < 17; i++) begin
      bus.i_console_stb  = 1'b1;
      bus.i_console_data = 7'(32'h60 + i);
      tick();
      if (i == 14) begin
        n_cmp++; if (bus.o_console_busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_at15: got %0h expected 0", bus.o_console_busy); end
      end
    end
    bus.i_console_stb = 1'b0;
    n_cmp++; if (bus.o_console_fill !== 5'd16) begin n_bad++; $display("FAIL full_fill: got %0d expected 16", bus.o_console_fill); end
    n_cmp++; if (bus.o_console_busy !== 1'b1) begin n_bad++; $display("FAIL full_busy: got %0h expected 1", bus.o_console_busy); end
    bus.i_tx_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== 8'(32'h60 + i)) begin n_bad++; $display("FAIL full_drain[%0d]: got stb=%0h data=%0h expected 1/%0h", i, bus.o_tx_stb, bus.o_tx_data, 32'h60 + i); end
      if (i == 0) begin
        n_cmp++; if (bus.o_console_busy !== 1'b0) begin n_bad++; $display("FAIL full_busy_drop: got %0h expected 0", bus.o_console_busy); end
      end
    end
    tick();
    n_cmp++; if (bus.o_tx_stb !== 1'b0 || bus.o_console_fill !== 5'd0) begin n_bad++; $display("FAIL full_end: got stb=%0h fill=%0d expected 0/0", bus.o_tx_stb, bus.o_console_fill); end
  endtask

  task automatic test_starvation;
    logic [7:0] exp_data;
    // The first 0xD5 is granted before 0x30 reaches the FIFO head; eight more follow while it waits
    bus.i_dbg_stb  = 1'b1;
    bus.i_dbg_data = 7'h55;
    for (int c = 0; c < 11; c++) begin
      bus.i_console_stb  = (c == 0);
      bus.i_console_data = 7'h30;
      #1;
      n_cmp++; if (bus.o_dbg_busy !== (c == 9)) begin n_bad++; $display("FAIL starve_dbg_busy[%0d]: got %0h expected %0h", c, bus.o_dbg_busy, (c == 9)); end
      tick();
      exp_data = (c == 9) ? 8'h30 : 8'hD5;
      n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== exp_data) begin n_bad++; $display("FAIL starve_tx[%0d]: got stb=%0h data=%0h expected 1/%0h", c, bus.o_tx_stb, bus.o_tx_data, exp_data); end
    end
    bus.i_dbg_stb     = 1'b0;
    bus.i_console_stb = 1'b0;
    tick();
  endtask

  task automatic test_port_inactive;
    bus.i_cmd_port_active = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.i_dbg_stb      = (c < 5);
      bus.i_dbg_data     = 7'(c + 1);
      bus.i_console_stb  = (c == 0);
      bus.i_console_data = 7'h7E;
      #1;
      n_cmp++; if (bus.o_dbg_busy !== 1'b0) begin n_bad++; $display("FAIL inactive_dbg_busy[%0d]: got %0h expected 0", c, bus.o_dbg_busy); end
      tick();
      n_cmp++; if (bus.o_tx_stb !== (c == 1)) begin n_bad++; $display("FAIL inactive_stb[%0d]: got %0h expected %0h", c, bus.o_tx_stb, (c == 1)); end
      if (c == 1) begin
        n_cmp++; if (bus.o_tx_data !== 8'h7E) begin n_bad++; $display("FAIL inactive_data: got %0h expected 7e", bus.o_tx_data); end
      end
    end
    bus.i_dbg_stb         = 1'b0;
    bus.i_console_stb     = 1'b0;
    bus.i_cmd_port_active = 1'b1;
  endtask

  task automatic test_tx_stall;
    bus.i_dbg_stb  = 1'b1;
    bus.i_dbg_data = 7'h41;
    #1;
    n_cmp++; if (bus.o_dbg_busy !== 1'b0) begin n_bad++; $display("FAIL stall_first_accept: got %0h expected 0", bus.o_dbg_busy); end
    tick();
    n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== 8'hC1) begin n_bad++; $display("FAIL stall_load: got stb=%0h data=%0h expected 1/c1", bus.o_tx_stb, bus.o_tx_data); end
    bus.i_tx_busy  = 1'b1;
    bus.i_dbg_data = 7'h22;
    for (int c = 0; c < 10; c++) begin
      bus.i_console_stb  = (c == 0);
      bus.i_console_data = 7'h33;
      #1;
      n_cmp++; if (bus.o_dbg_busy !== 1'b1) begin n_bad++; $display("FAIL stall_dbg_busy[%0d]: got %0h expected 1", c, bus.o_dbg_busy); end
      tick();
      n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== 8'hC1) begin n_bad++; $display("FAIL stall_hold[%0d]: got stb=%0h data=%0h expected 1/c1", c, bus.o_tx_stb, bus.o_tx_data); end
    end
    bus.i_console_stb = 1'b0;
    bus.i_tx_busy     = 1'b0;
    #1;
    n_cmp++; if (bus.o_dbg_busy !== 1'b0) begin n_bad++; $display("FAIL stall_release_accept: got %0h expected 0", bus.o_dbg_busy); end
    tick();
    n_cmp++; if (bus.o_tx_data !== 8'hA2) begin n_bad++; $display("FAIL stall_release_data: got %0h expected a2", bus.o_tx_data); end
    bus.i_dbg_stb = 1'b0;
    tick();
    n_cmp++; if (bus.o_tx_stb !== 1'b1 || bus.o_tx_data !== 8'h33) begin n_bad++; $display("FAIL stall_console: got stb=%0h data=%0h expected 1/33", bus.o_tx_stb, bus.o_tx_data); end
    tick();
    n_cmp++; if (bus.o_tx_stb !== 1'b0) begin n_bad++; $display("FAIL stall_end_stb: got %0h expected 0", bus.o_tx_stb); end
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.i_cmd_port_active = 1'b1;
    bus.i_dbg_stb         = 1'b0;
    bus.i_dbg_data        = 7'h00;
    bus.i_console_stb     = 1'b0;
    bus.i_console_data    = 7'h00;
    bus.i_tx_busy         = 1'b0;
    test_reset();
    test_console_only();
    test_fifo_full();
    test_starvation();
    test_port_inactive();
    test_tx_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
